// File: rtl/uart_loader_pkg.sv
// Shared types and helpers for the UART program loader.
// Holds the FSM encoding, header length and bytes-per-word helper.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam int HDR_BYTES = 2;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/uart_word_packer.sv
// Packs a little-endian byte stream into DATA_W words.
// Ports: clr/push/data in; word (with current byte inserted) and last out.
module uart_word_packer
  import uart_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [7:0]        data,
  output logic [DATA_W-1:0] word,
  output logic              last
);

  localparam int BPW = bytes_per_word(DATA_W);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] acc;

  // word is the accumulator with the incoming byte already in place,
  // so the top can capture a complete word on the last byte.
  always_comb begin
    word = acc;
    word[int'(idx)*8 +: 8] = data;
    last = push && (idx == IW'(BPW - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      acc <= '0;
    end else if (clr) begin
      idx <= '0;
      acc <= '0;
    end else if (push) begin
      if (last) begin
        idx <= '0;
        acc <= '0;
      end else begin
        idx <= idx + IW'(1);
        acc <= word;
      end
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a length-prefixed UART byte stream into program memory.
// Ports: i_start/i_rx_dv/i_rx_byte in; o_mem_* write port,
// o_busy/o_cpu_hold/o_done/o_err status out.
// Optional trailing checksum byte: define UART_LOADER_CHKSUM_EN.
module uart_prog_loader
  import uart_loader_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_rx_dv,
  input  logic [7:0]        i_rx_byte,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_busy,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_err
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;
  localparam bit NO_LIMIT = (ADDR_W >= 16);

  state_t            state;
  state_t            nxt;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        len_lo;
  logic [15:0]       words_left;
  logic [TW-1:0]     tmo_cnt;
  logic [DATA_W-1:0] word;
  logic              last;
  logic              accept;
  logic              go;
  logic              act;
  logic              tmo;
  logic              final_word;
  logic              too_big;
  logic [15:0]       cnt;

`ifdef UART_LOADER_CHKSUM_EN
  logic [7:0] sum;
`else
  // Set for the cycle the final write strobe is on the port.
  logic fin;
`endif

  assign o_cpu_hold = o_busy;

  assign act = (state == S_LEN_LO) || (state == S_LEN_HI) ||
               (state == S_DATA) || (state == S_CHK);
  assign go  = i_start && (state == S_IDLE || state == S_DONE ||
                           state == S_ERR);
  assign tmo = (tmo_cnt == TW'(TIMEOUT_CLKS - 1));
  assign cnt = {i_rx_byte, len_lo};
  assign too_big = !NO_LIMIT && ({1'b0, cnt} > MAX_WORDS);

`ifdef UART_LOADER_CHKSUM_EN
  assign accept = i_rx_dv && (state == S_DATA);
`else
  assign accept = i_rx_dv && (state == S_DATA) && !fin;
`endif

  assign final_word = last && (words_left == 16'd1);

  uart_word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != S_DATA),
    .push  (accept),
    .data  (i_rx_byte),
    .word  (word),
    .last  (last)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_start) nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (i_rx_dv)  nxt = S_LEN_HI;
        else if (tmo) nxt = S_ERR;
      end
      S_LEN_HI: begin
        if (i_rx_dv) begin
`ifdef UART_LOADER_CHKSUM_EN
          if (cnt == 16'd0)  nxt = S_CHK;
`else
          if (cnt == 16'd0)  nxt = S_DONE;
`endif
          else if (too_big) nxt = S_ERR;
          else              nxt = S_DATA;
        end else if (tmo) begin
          nxt = S_ERR;
        end
      end
      S_DATA: begin
`ifdef UART_LOADER_CHKSUM_EN
        if (final_word)        nxt = S_CHK;
        else if (!i_rx_dv && tmo) nxt = S_ERR;
`else
        if (fin)               nxt = S_DONE;
        else if (!i_rx_dv && tmo) nxt = S_ERR;
`endif
      end
`ifdef UART_LOADER_CHKSUM_EN
      S_CHK: begin
        if (i_rx_dv)
          nxt = (i_rx_byte == sum) ? S_DONE : S_ERR;
        else if (tmo)
          nxt = S_ERR;
      end
`endif
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      addr        <= '0;
      len_lo      <= '0;
      words_left  <= '0;
      tmo_cnt     <= '0;
`ifdef UART_LOADER_CHKSUM_EN
      sum         <= '0;
`else
      fin         <= 1'b0;
`endif
    end else begin
      state    <= nxt;
      o_busy   <= (nxt == S_LEN_LO) || (nxt == S_LEN_HI) ||
                  (nxt == S_DATA) || (nxt == S_CHK);
      o_done   <= (nxt == S_DONE);
      o_err    <= (nxt == S_ERR);
      o_mem_we <= last;

      if (go) begin
        addr <= '0;
      end else if (last) begin
        o_mem_addr  <= addr;
        o_mem_wdata <= word;
        addr        <= addr + ADDR_W'(1);
        words_left  <= words_left - 16'd1;
      end

      if (state == S_LEN_LO && i_rx_dv) len_lo <= i_rx_byte;
      if (state == S_LEN_HI && i_rx_dv) words_left <= cnt;

      if (go || i_rx_dv || !act) tmo_cnt <= '0;
      else if (!tmo)             tmo_cnt <= tmo_cnt + TW'(1);

`ifdef UART_LOADER_CHKSUM_EN
      if (go)
        sum <= '0;
      else if (i_rx_dv && (state == S_LEN_LO ||
                           state == S_LEN_HI || accept))
        sum <= sum + i_rx_byte;
`else
      fin <= final_word;
`endif
    end
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Sequences the byte stream from the UART receiver into program memory. It parses a length header, packs bytes into memory words and writes them to consecutive addresses. While a load is in progress it holds the processor in reset. It sits between the UART receiver's data-valid/byte outputs and the instruction-memory write port, and is the only writer of that port during boot.

## Interface
- ADDR_W, 8: memory word-address width.
- DATA_W, 32: memory word width. Must be a multiple of 8, range 8..32.
- TIMEOUT_CLKS, 100000: maximum idle clocks allowed between bytes during a load.
- clk  in  1  system clock. One clock domain; all logic is on the rising edge.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- i_start  in  1  one-cycle pulse. Arms a new load.
- i_rx_dv  in  1  one-cycle pulse. A received byte is valid.
- i_rx_byte  in  8  received byte. Valid only when i_rx_dv=1.
- o_mem_we  out  1  one-cycle word write strobe.
- o_mem_addr  out  ADDR_W  word address for the write.
- o_mem_wdata  out  DATA_W  packed word for the write.
- o_busy  out  1  load in progress.
- o_cpu_hold  out  1  holds the processor in reset. Equal to o_busy.
- o_done  out  1  last load completed OK. Level signal.
- o_err  out  1  last load failed. Level signal.

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR.
- IDLE, DONE, ERR:
  - i_start moves to LEN_LO.
  - On that transition, clear o_done, o_err, the word address, the byte index and the checksum.
- i_start while busy is ignored.
- LEN_LO: the first byte is the word count, bits [7:0].
- LEN_HI: the second byte is the word count, bits [15:8].
  - Count = 0 goes to CHK if the checksum is compiled in, else DONE.
  - Count > 2^ADDR_W goes to ERR.
  - Otherwise go to DATA.
- DATA: bytes arrive little-endian. Byte k of a word goes to bits [8k+7:8k].
  - On the last byte of a word, register the full word and address.
  - Pulse o_mem_we in the next cycle.
  - Increment the address after the write.
  - After the final word, go to CHK (if compiled in) or DONE.
- DONE: o_done=1, o_busy=0.
- ERR: o_err=1, o_busy=0.
- Timeout:
  - A counter clears on every i_rx_dv and on entry to LEN_LO.
  - In LEN_LO, LEN_HI, DATA or CHK, reaching TIMEOUT_CLKS goes to ERR.
  - A partial word already received is discarded and not written.
- i_rx_dv in IDLE, DONE or ERR is ignored.
- Address arithmetic: ADDR_W bits. A load of exactly 2^ADDR_W words ends with the address wrapped to 0, which is legal.

## Timing
- Reset values:
  - State IDLE.
  - o_mem_we=0, o_mem_addr=0, o_mem_wdata=0.
  - o_busy=0, o_cpu_hold=0, o_done=0, o_err=0.
- rst_n asserted mid-load aborts immediately to IDLE. No write strobe appears after reset.
- o_busy rises the cycle after i_start is sampled.
- o_mem_we is asserted exactly 1 cycle after the i_rx_dv of a word's last byte. It is high for exactly 1 cycle.
  - o_mem_addr and o_mem_wdata are stable while o_mem_we=1.
- o_done and o_busy=0 appear 1 cycle after the final byte (or after the final write strobe when the checksum is not compiled in).
  - Either way, o_busy falls in the same cycle that o_done rises.
- A byte arriving in the same cycle as the timeout expiry is accepted; the timeout loses.
- Back-to-back i_rx_dv on consecutive cycles must be handled. There are no throughput gaps.

## Configuration
- UART_LOADER_CHKSUM_EN:
  - Defined: after the data, one extra byte is expected. It must equal the 8-bit modular sum of all header and data bytes.
    - Match goes to DONE.
    - Mismatch goes to ERR. Words already written remain in memory.
  - Undefined: the CHK state, the checksum register and its compare logic are absent. The final word goes straight to DONE.

## Structure
- Package uart_loader_pkg holds:
  - the state enum encoding;
  - the header length (2 bytes);
  - a function returning bytes-per-word from DATA_W.
- One sub-module, uart_word_packer: the byte index counter, the shift/insert into the word register and the word-complete pulse.
- The FSM, timeout counter, address counter and checksum stay in the top.

## Test plan
- DATA_W=32, header 02 00, bytes 11 22 33 44 55 66 77 88 → writes 0x44332211@0 then 0x88776655@1; o_done=1, o_cpu_hold=0.
- Header 00 00 → no o_mem_we; o_done=1 (checksum byte 00 required when UART_LOADER_CHKSUM_EN is defined).
- Header 01 00, then 2 of 4 data bytes, then silence for TIMEOUT_CLKS → o_err=1, no write, o_busy=0.
- Header 01 00, data AA BB CC DD, checksum 0x00 (correct sum is 0x0F) → word 0xDDCCBBAA written at 0, then o_err=1.
- rst_n pulsed low after the first data byte → all outputs return to 0 at once; a subsequent i_start with a full 1-word load completes correctly at address 0.
- i_start pulsed during DATA → ignored, and the load completes normally.
